// File: rtl/mul_div_unit_if.sv
// E-stage multiply/divide bus: issue side (en/mdOp/operands) and result/status side.
interface mul_div_unit_if;
    logic        en;
    logic [3:0]  mdOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] out;

    modport master (output en, mdOp, A, B, input start, busy, HI, LO, out);
    modport slave  (input en, mdOp, A, B, output start, busy, HI, LO, out);
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Results are computed at issue and held in pend_* until the latency counter expires.
//
//   state  | meaning
//   S_IDLE | no operation in flight; accepts mult/div starts and mthi/mtlo
//   S_RUN  | operation in flight; cnt counts down, HI/LO commit when cnt==1
module mul_div_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic [31:0]        hi_q, lo_q;
    logic [31:0]        pend_hi, pend_lo;
    logic               pend_wr;

    logic               is_md;
    logic               start;
    logic [63:0]        sprod, uprod;
    logic [31:0]        res_hi, res_lo;
    logic               res_wr;

    assign is_md = (bus.mdOp >= OP_MULT) && (bus.mdOp <= OP_DIVU);
    assign start = bus.en && !busy_q && is_md;

    assign sprod = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign uprod = {32'd0, bus.A} * {32'd0, bus.B};

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        case (bus.mdOp)
            OP_MULT:  {res_hi, res_lo} = sprod;
            OP_MULTU: {res_hi, res_lo} = uprod;
            OP_DIV: begin
                if (bus.B == 32'd0) begin
                    res_wr = 1'b0;
                end else if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
                    // most-negative / -1 wraps rather than trapping
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = $signed(bus.A) / $signed(bus.B);
                    res_hi = $signed(bus.A) % $signed(bus.B);
                end
            end
            OP_DIVU: begin
                if (bus.B == 32'd0) begin
                    res_wr = 1'b0;
                end else begin
                    res_lo = bus.A / bus.B;
                    res_hi = bus.A % bus.B;
                end
            end
            default: res_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        pend_wr <= res_wr;
                        cnt     <= (bus.mdOp == OP_MULT || bus.mdOp == OP_MULTU) ?
                                   CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
                        busy_q  <= 1'b1;
                        state   <= S_RUN;
                    end else if (bus.en && bus.mdOp == OP_MTHI) begin
                        hi_q <= bus.A;
                    end else if (bus.en && bus.mdOp == OP_MTLO) begin
                        lo_q <= bus.A;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (pend_wr) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.start = start;
    assign bus.busy  = busy_q;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign bus.out   = !bus.en ? 32'd0 :
                       (bus.mdOp == OP_MFHI) ? hi_q :
                       (bus.mdOp == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vectors plus random traffic against a cycle-level
// model that computes results with 64-bit integer arithmetic.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;

    mul_div_unit_if bus ();

    mul_div_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference state
    logic [31:0] m_hi, m_lo, m_rh, m_rl;
    logic        m_rv;
    int          m_left;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_hi = 32'd0; m_lo = 32'd0; m_rh = 32'd0; m_rl = 32'd0; m_rv = 1'b0; m_left = 0;
    endtask

    task automatic m_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic v, output logic [31:0] h, output logic [31:0] l);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        v = 1'b1; h = 32'd0; l = 32'd0;
        case (op)
            4'd1: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
            4'd2: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
            4'd3: if (b == 0) v = 1'b0;
                  else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
            4'd4: if (b == 0) v = 1'b0;
                  else begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
            default: v = 1'b0;
        endcase
    endtask

    // drive one cycle, check mid-cycle, then advance the model at the edge
    task automatic step(input logic e, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic exp_start;
        logic [31:0] exp_out;
        bus.en = e; bus.mdOp = op; bus.A = a; bus.B = b;
        @(negedge clk);
        exp_start = e && (m_left == 0) && (op >= 4'd1) && (op <= 4'd4);
        exp_out   = !e ? 32'd0 : (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
        check_val("start", {31'd0, bus.start}, {31'd0, exp_start});
        check_val("busy",  {31'd0, bus.busy},  {31'd0, m_left > 0});
        check_val("hi",    bus.HI, m_hi);
        check_val("lo",    bus.LO, m_lo);
        check_val("out",   bus.out, exp_out);
        @(posedge clk);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_rv) begin m_hi = m_rh; m_lo = m_rl; end
        end else if (e) begin
            if (exp_start) begin
                m_compute(op, a, b, m_rv, m_rh, m_rl);
                m_left = (op <= 4'd2) ? 5 : 10;
            end else if (op == 4'd5) m_hi = a;
            else if (op == 4'd6) m_lo = a;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic [3:0] op);
        for (int i = 0; i < n; i++) step(1'b1, op, $urandom, $urandom);
    endtask

    initial begin
        logic        e;
        logic [3:0]  op;
        logic [31:0] a, b;
        bus.en = 1'b0; bus.mdOp = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_hi", bus.HI, 32'd0);
        check_val("rst_lo", bus.LO, 32'd0);
        reset = 1'b1;

        step(1, 4'd5, 32'h1234, 0);
        step(1, 4'd8, 0, 0);
        check_val("mthi_hi", bus.HI, 32'h0000_1234);

        step(1, 4'd1, 32'hFFFF_FFFE, 3);
        idle(5, 4'd0);
        step(1, 4'd0, 0, 0);
        check_val("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check_val("mult_lo", bus.LO, 32'hFFFF_FFFA);

        step(1, 4'd2, 32'hFFFF_FFFE, 3);
        idle(5, 4'd7);
        check_val("multu_hi", bus.HI, 32'h0000_0002);
        check_val("multu_lo", bus.LO, 32'hFFFF_FFFA);

        step(1, 4'd3, 32'hFFFF_FFF9, 2);
        idle(10, 4'd8);
        check_val("div_lo", bus.LO, 32'hFFFF_FFFD);
        check_val("div_hi", bus.HI, 32'hFFFF_FFFF);

        step(1, 4'd4, 7, 2);
        idle(10, 4'd0);
        check_val("divu_lo", bus.LO, 32'd3);
        check_val("divu_hi", bus.HI, 32'd1);

        step(1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(10, 4'd0);
        check_val("ovf_lo", bus.LO, 32'h8000_0000);
        check_val("ovf_hi", bus.HI, 32'd0);

        step(1, 4'd5, 32'hAA, 0);
        step(1, 4'd6, 32'hBB, 0);
        step(1, 4'd4, 5, 0);
        idle(10, 4'd7);
        check_val("dz_hi", bus.HI, 32'hAA);
        check_val("dz_lo", bus.LO, 32'hBB);

        // mult while busy is dropped; reset in the 3rd busy cycle clears everything at once
        step(1, 4'd1, 32'd100, 32'd7);
        step(1, 4'd1, 32'd9, 32'd9);
        step(1, 4'd5, 32'h5555, 0);
        reset = 1'b0;
        #1;
        m_reset();
        check_val("arst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("arst_hi", bus.HI, 32'd0);
        check_val("arst_lo", bus.LO, 32'd0);
        #1 reset = 1'b1;
        step(1, 4'd0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            e  = ($urandom_range(0, 9) != 0);
            op = 4'($urandom_range(0, 10));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            step(e, op, a, b);
        end
        for (int i = 0; i < 12; i++) step(0, 4'd7, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
